fifo_sched: RTL

- Scheduler that shares one 8-bit byte FIFO (DEPTH 10, push-priority, one-cycle registered pop) between N_REQ producers and a single valid/ready consumer.
- Producers are served round-robin. Push and pop are never issued in the same cycle. The FIFO's pop output is captured into a one-entry output register.
- Sits directly in front of the FIFO instance; all FIFO push/pop traffic passes through this block.

---
 rtl/fifo_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/fifo_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared constants and op encoding for the FIFO scheduler.
package fifo_sched_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 10;

  // One operation per cycle towards the FIFO; never push and pop together.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int PTR_W = $clog2(N_REQ);
  // One extra bit so ptr+k never overflows before the modulo wrap.
  localparam int CW    = PTR_W + 1;

  logic [CW-1:0] cand;

  // Scan N_REQ candidates starting at ptr; first asserted request wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!any && req[cand[PTR_W-1:0]]) begin
        any = 1'b1;
        idx = cand[PTR_W-1:0];
      end
    end
  end

  // Expand the winning index to a one-hot grant.
  always_comb begin
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_sched.sv
// Shares one byte FIFO between N_REQ round-robin producers and a single
// valid/ready consumer. One FIFO op per cycle; popped bytes land in a
// one-entry output register one cycle after the pop.
module fifo_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = fifo_sched_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    rd_ready,
  output logic                    fifo_push,
  output logic                    fifo_pop,
  output logic [DATA_W-1:0]       fifo_wdata,
  input  logic [DATA_W-1:0]       fifo_rdata,
  input  logic                    fifo_full,
  input  logic                    fifo_empty
);

  import fifo_sched_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                ptr_nxt;
  logic                            last_pop;
  logic                            cap_pend;
  logic [N_REQ-1:0]                arb_gnt;
  logic                            arb_any;
  logic [PTR_W-1:0]                arb_idx;
  logic [N_REQ-1:0][DATA_W-1:0]    req_bytes;
  logic                            push_ok;
  logic                            pop_ok;
  op_e                             op;

  assign req_bytes = req_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .any (arb_any),
    .idx (arb_idx)
  );

  // Pointer moves to the slot just past this cycle's winner.
  assign ptr_nxt = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // Pick the single FIFO op; when both sides are eligible, alternate so
  // neither producers nor the consumer can starve the other.
  always_comb begin
    push_ok = arb_any && !fifo_full;
    pop_ok  = !fifo_empty && !cap_pend && (!rd_valid || rd_ready);
    op      = OP_NONE;
    if (reset)                op = OP_NONE;
    else if (push_ok && pop_ok) op = last_pop ? OP_PUSH : OP_POP;
    else if (push_ok)         op = OP_PUSH;
    else if (pop_ok)          op = OP_POP;
  end

  // Drive FIFO controls and the producer grant from the chosen op.
  always_comb begin
    gnt        = '0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_wdata = '0;
    case (op)
      OP_PUSH: begin
        gnt        = arb_gnt;
        fifo_push  = 1'b1;
        fifo_wdata = req_bytes[arb_idx];
      end
      OP_POP:  fifo_pop = 1'b1;
      default: ;
    endcase
  end

  // Arbitration history: round-robin pointer and which side went last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      last_pop <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          rr_ptr   <= ptr_nxt;
          last_pop <= 1'b0;
        end
        OP_POP:  last_pop <= 1'b1;
        default: ;
      endcase
    end
  end

  // Output register: capture the FIFO's registered data one cycle after a
  // pop; a consumer handshake empties it. A pop is only issued when the
  // register will be free, so capture never overwrites a live byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_pend <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      if (cap_pend) begin
        rd_data  <= fifo_rdata;
        rd_valid <= 1'b1;
        cap_pend <= 1'b0;
      end
      if (op == OP_POP) cap_pend <= 1'b1;
    end
  end

endmodule
